// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt/exception sequencer:
// FSM states, config register map, cause layout and default vectors.
package irq_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLUSH  = 2'd1,
    S_VECTOR = 2'd2,
    S_KERNEL = 2'd3
  } irq_state_e;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_CAUSE   = 2'd2;
  localparam logic [1:0] ADDR_EPC     = 2'd3;

  localparam int unsigned CAUSE_EXC_BIT = 31;
  localparam int unsigned CAUSE_CODE_W  = 3;
  localparam int unsigned MASK_GIE_BIT  = 31;

  localparam logic [31:0] INT_VEC_DEFAULT = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC_DEFAULT = 32'h8000_0008;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Fixed-priority encoder: reports the lowest set request index,
// so source 0 always wins.
module prio_enc #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Scanning from the top down lets the lowest index overwrite the result last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt/exception sequencer for the 5-stage MIPS pipeline: latches and
// prioritises events, drives flush, vector load and kernel-mode tracking.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter logic [31:0] INT_VEC      = INT_VEC_DEFAULT,
  parameter logic [31:0] EXC_VEC      = EXC_VEC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               exc_req,
  input  logic [2:0]         exc_code,
  input  logic [31:0]        epc_in,
  input  logic               stall,
  input  logic               eret,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               flush,
  output logic               vector_valid,
  output logic [31:0]        vector_pc,
  output logic               kernel_mode,
  output logic               double_fault
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  irq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   flushCnt_q, flushCnt_d;
  logic [NUM_SRC-1:0] irqPrev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic               gie_q, gie_d;
  logic               excPend_q, excPend_d;
  logic [2:0]         excCode_q, excCode_d;
  logic [31:0]        cause_q, cause_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        vectorPc_q, vectorPc_d;
  logic               doubleFault_q, doubleFault_d;

  logic [NUM_SRC-1:0] irqRise;
  logic [NUM_SRC-1:0] enabledPend;
  logic               irqValid;
  logic [IDX_W-1:0]   irqIdx;
  logic               inKernel;
  logic               excNow;
  logic               excAvail;
  logic [2:0]         excCodeNow;
  logic               canTake;
  logic               takeExc;
  logic               takeIrq;
  logic               cfgWrPending;
  logic               cfgWrMask;
  logic               unused_wdata;

  assign irqRise      = irq_src & ~irqPrev_q;
  assign inKernel     = (state_q == S_KERNEL);
  assign excNow       = exc_req && !inKernel;
  // A fresh exc_req is takeable in the same cycle, before it reaches the latch.
  assign excAvail     = excPend_q || excNow;
  assign excCodeNow   = excNow ? exc_code : excCode_q;
  assign enabledPend  = gie_q ? (pending_q & enable_q) : '0;
  assign canTake      = (state_q == S_IDLE) && !stall;
  assign takeExc      = canTake && excAvail;
  assign takeIrq      = canTake && !excAvail && irqValid;
  assign cfgWrPending = cfg_we && (cfg_addr == ADDR_PENDING);
  assign cfgWrMask    = cfg_we && (cfg_addr == ADDR_MASK);
  assign unused_wdata = ^cfg_wdata[30:NUM_SRC];

  prio_enc #(
    .N  (NUM_SRC),
    .IW (IDX_W)
  ) u_prio_enc (
    .req_i   (enabledPend),
    .valid_o (irqValid),
    .idx_o   (irqIdx)
  );

  always_comb begin
    pending_d = pending_q;
    if (cfgWrPending) begin
      pending_d = pending_d & ~cfg_wdata[NUM_SRC-1:0];
    end
    if (takeIrq) begin
      pending_d[irqIdx] = 1'b0;
    end
    // New edges are applied last so they survive a simultaneous clear.
    pending_d = pending_d | irqRise;

    gie_d    = gie_q;
    enable_d = enable_q;
    if (cfgWrMask) begin
      gie_d    = cfg_wdata[MASK_GIE_BIT];
      enable_d = cfg_wdata[NUM_SRC-1:0];
    end

    excPend_d     = excPend_q;
    excCode_d     = excCode_q;
    doubleFault_d = doubleFault_q;
    if (excNow) begin
      excPend_d = 1'b1;
      excCode_d = exc_code;
    end
    if (exc_req && inKernel) begin
      doubleFault_d = 1'b1;
    end
    if (takeExc) begin
      excPend_d = 1'b0;
    end

    cause_d = cause_q;
    epc_d   = epc_q;
    if (takeExc) begin
      cause_d                      = '0;
      cause_d[CAUSE_EXC_BIT]       = 1'b1;
      cause_d[CAUSE_CODE_W-1:0]    = excCodeNow;
      epc_d                        = epc_in;
    end else if (takeIrq) begin
      cause_d                      = '0;
      cause_d[CAUSE_CODE_W-1:0]    = CAUSE_CODE_W'(irqIdx);
      epc_d                        = epc_in;
    end
  end

  // vector_pc only changes on entry to VECTOR so it is stable everywhere else.
  always_comb begin
    state_d    = state_q;
    flushCnt_d = flushCnt_q;
    vectorPc_d = vectorPc_q;
    case (state_q)
      S_IDLE: begin
        if (takeExc || takeIrq) begin
          state_d    = S_FLUSH;
          flushCnt_d = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      S_FLUSH: begin
        if (flushCnt_q == '0) begin
          state_d    = S_VECTOR;
          vectorPc_d = cause_q[CAUSE_EXC_BIT] ? EXC_VEC : INT_VEC;
        end else begin
          flushCnt_d = flushCnt_q - CNT_W'(1);
        end
      end
      S_VECTOR: state_d = S_KERNEL;
      S_KERNEL: begin
        if (eret) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      flushCnt_q    <= '0;
      irqPrev_q     <= '0;
      pending_q     <= '0;
      enable_q      <= '0;
      gie_q         <= 1'b0;
      excPend_q     <= 1'b0;
      excCode_q     <= '0;
      cause_q       <= '0;
      epc_q         <= '0;
      vectorPc_q    <= '0;
      doubleFault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flushCnt_q    <= flushCnt_d;
      irqPrev_q     <= irq_src;
      pending_q     <= pending_d;
      enable_q      <= enable_d;
      gie_q         <= gie_d;
      excPend_q     <= excPend_d;
      excCode_q     <= excCode_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      vectorPc_q    <= vectorPc_d;
      doubleFault_q <= doubleFault_d;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_PENDING: cfg_rdata[NUM_SRC-1:0] = pending_q;
      ADDR_MASK: begin
        cfg_rdata[MASK_GIE_BIT]  = gie_q;
        cfg_rdata[NUM_SRC-1:0]   = enable_q;
      end
      ADDR_CAUSE: cfg_rdata = cause_q;
      ADDR_EPC:   cfg_rdata = epc_q;
      default:    cfg_rdata = '0;
    endcase
  end

  assign flush        = (state_q == S_FLUSH);
  assign vector_valid = (state_q == S_VECTOR);
  assign kernel_mode  = (state_q == S_VECTOR) || (state_q == S_KERNEL);
  assign vector_pc    = vectorPc_q;
  assign double_fault = doubleFault_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed-vector bench for irq_ctrl with hand-computed expectations:
// interrupt/exception sequencing, stall, double fault, W1C and reset abort.
module tb_irq_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_src;
  logic        exc_req;
  logic [2:0]  exc_code;
  logic [31:0] epc_in;
  logic        stall;
  logic        eret;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        flush;
  logic        vector_valid;
  logic [31:0] vector_pc;
  logic        kernel_mode;
  logic        double_fault;

  int vectors = 0;
  int miscompares = 0;

  irq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .irq_src      (irq_src),
    .exc_req      (exc_req),
    .exc_code     (exc_code),
    .epc_in       (epc_in),
    .stall        (stall),
    .eret         (eret),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_rdata    (cfg_rdata),
    .flush        (flush),
    .vector_valid (vector_valid),
    .vector_pc    (vector_pc),
    .kernel_mode  (kernel_mode),
    .double_fault (double_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge(s); one-cycle pulses drop back to 0.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      exc_req = 1'b0;
      eret    = 1'b0;
      cfg_we  = 1'b0;
    end
  endtask

  task automatic expectPins(input string tag, input logic f, input logic vv, input logic km, input logic df);
    @(negedge clk);
    checkOutput({tag, ".flush"}, 32'(flush), 32'(f));
    checkOutput({tag, ".vvalid"}, 32'(vector_valid), 32'(vv));
    checkOutput({tag, ".kmode"}, 32'(kernel_mode), 32'(km));
    checkOutput({tag, ".dfault"}, 32'(double_fault), 32'(df));
  endtask

  task automatic checkReg(input string tag, input logic [1:0] addr, input logic [31:0] expected);
    cfg_addr = addr;
    #1;
    checkOutput(tag, cfg_rdata, expected);
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
    applyStimulus(1);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
  endtask

  initial begin
    reset = 1'b1; irq_src = '0; exc_req = 1'b0; exc_code = '0; epc_in = '0;
    stall = 1'b0; eret = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;

    // Reset state
    expectPins("rst", 0, 0, 0, 0);
    checkOutput("rst.vpc", vector_pc, 32'h0);
    checkReg("rst.pending", 2'd0, 32'h0);
    checkReg("rst.mask", 2'd1, 32'h0);
    checkReg("rst.cause", 2'd2, 32'h0);
    checkReg("rst.epc", 2'd3, 32'h0);
    applyStimulus(2);
    reset = 1'b0;

    // Timer interrupt: edge at E, flush E+2..E+4, vector at E+5
    writeReg(2'd1, 32'h8000_0001);
    applyStimulus(1);
    checkReg("t1.mask", 2'd1, 32'h8000_0001);
    applyStimulus(1);
    irq_src = 4'b0001;
    epc_in  = 32'h0000_0100;
    expectPins("t1.edge", 0, 0, 0, 0);
    applyStimulus(1);
    expectPins("t1.take", 0, 0, 0, 0);
    checkReg("t1.pendtake", 2'd0, 32'h1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      expectPins("t1.flush", 1, 0, 0, 0);
    end
    applyStimulus(1);
    expectPins("t1.vec", 0, 1, 1, 0);
    checkOutput("t1.vpc", vector_pc, 32'h8000_0004);
    checkReg("t1.cause", 2'd2, 32'h0);
    checkReg("t1.pending", 2'd0, 32'h0);
    checkReg("t1.epc", 2'd3, 32'h0000_0100);
    applyStimulus(1);
    eret = 1'b1;
    expectPins("t1.eret", 0, 0, 1, 0);
    applyStimulus(1);
    irq_src = 4'b0000;
    expectPins("t1.idle", 0, 0, 0, 0);
    checkOutput("t1.vpchold", vector_pc, 32'h8000_0004);

    // Exception beats a simultaneous uart edge; uart follows after eret
    writeReg(2'd1, 32'h8000_0003);
    applyStimulus(1);
    exc_req = 1'b1; exc_code = 3'd3; irq_src = 4'b0010; epc_in = 32'h0000_1000;
    expectPins("t2.take", 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      expectPins("t2.flush", 1, 0, 0, 0);
    end
    applyStimulus(1);
    expectPins("t2.vec", 0, 1, 1, 0);
    checkOutput("t2.vpc", vector_pc, 32'h8000_0008);
    checkReg("t2.cause", 2'd2, 32'h8000_0003);
    checkReg("t2.epc", 2'd3, 32'h0000_1000);
    checkReg("t2.pending", 2'd0, 32'h2);
    applyStimulus(1);
    eret = 1'b1;
    applyStimulus(1);
    epc_in = 32'h0000_2000;
    expectPins("t2.utake", 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      expectPins("t2.uflush", 1, 0, 0, 0);
    end
    applyStimulus(1);
    expectPins("t2.uvec", 0, 1, 1, 0);
    checkOutput("t2.uvpc", vector_pc, 32'h8000_0004);
    checkReg("t2.ucause", 2'd2, 32'h1);
    checkReg("t2.uepc", 2'd3, 32'h0000_2000);
    checkReg("t2.upending", 2'd0, 32'h0);
    applyStimulus(1);
    eret = 1'b1; irq_src = 4'b0000;

    // Exception pulse during a 5-cycle stall is held until stall drops
    applyStimulus(1);
    stall = 1'b1; exc_req = 1'b1; exc_code = 3'd5; epc_in = 32'h0000_3000;
    expectPins("t3.stall", 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1);
      epc_in = 32'h0000_3004;
      expectPins("t3.stall", 0, 0, 0, 0);
    end
    applyStimulus(1);
    stall = 1'b0; epc_in = 32'h0000_4444;
    expectPins("t3.take", 0, 0, 0, 0);
    applyStimulus(1);
    epc_in = 32'h0000_5555;
    expectPins("t3.flush0", 1, 0, 0, 0);
    applyStimulus(2);
    applyStimulus(1);
    expectPins("t3.vec", 0, 1, 1, 0);
    checkOutput("t3.vpc", vector_pc, 32'h8000_0008);
    checkReg("t3.cause", 2'd2, 32'h8000_0005);
    checkReg("t3.epc", 2'd3, 32'h0000_4444);

    // Exception inside the handler: double fault, no second vector
    applyStimulus(1);
    exc_req = 1'b1; exc_code = 3'd2;
    expectPins("t4.exc", 0, 0, 1, 0);
    applyStimulus(1);
    expectPins("t4.df", 0, 0, 1, 1);
    applyStimulus(1);
    eret = 1'b1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1);
      expectPins("t4.after", 0, 0, 0, 1);
    end
    checkReg("t4.cause", 2'd2, 32'h8000_0005);

    // GIE=0: edge pends without a take; W1C and set-over-clear
    writeReg(2'd1, 32'h0000_0001);
    applyStimulus(1);
    irq_src = 4'b0001;
    applyStimulus(1);
    expectPins("t5.noflush", 0, 0, 0, 1);
    checkReg("t5.pend", 2'd0, 32'h1);
    applyStimulus(2);
    expectPins("t5.noflush2", 0, 0, 0, 1);
    writeReg(2'd0, 32'h0000_0001);
    applyStimulus(1);
    checkReg("t5.w1c", 2'd0, 32'h0);
    irq_src = 4'b0000;
    writeReg(2'd0, 32'h0000_0000);
    irq_src = 4'b0001;
    applyStimulus(1);
    checkReg("t5.w0edge", 2'd0, 32'h1);
    writeReg(2'd0, 32'h0000_0005);
    irq_src = 4'b0101;
    applyStimulus(1);
    checkReg("t5.w1cedge", 2'd0, 32'h4);

    // Reset in the middle of FLUSH
    writeReg(2'd1, 32'h8000_0004);
    applyStimulus(1);
    expectPins("t6.take", 0, 0, 0, 1);
    applyStimulus(1);
    expectPins("t6.flush", 1, 0, 0, 1);
    applyStimulus(1);
    reset = 1'b1; irq_src = 4'b0000;
    #1;
    checkOutput("t6.rst.flush", 32'(flush), 32'h0);
    checkOutput("t6.rst.vvalid", 32'(vector_valid), 32'h0);
    checkOutput("t6.rst.kmode", 32'(kernel_mode), 32'h0);
    checkOutput("t6.rst.dfault", 32'(double_fault), 32'h0);
    checkOutput("t6.rst.vpc", vector_pc, 32'h0);
    applyStimulus(1);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      expectPins("t6.idle", 0, 0, 0, 0);
    end
    checkReg("t6.pending", 2'd0, 32'h0);
    checkReg("t6.mask", 2'd1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt/exception sequencer for the 5-stage MIPS pipeline. It latches timer, UART and other interrupt requests plus synchronous exceptions, and prioritises them.
- It drives the pipeline flush, the kernel-vector PC load and kernel-mode tracking, then waits for eret before accepting the next event.
- It replaces the ad-hoc combinational Interrupt/Exception gating in the processor top level. Its configuration registers are reached via the peripheral bus.

Parameters:
- NUM_SRC, 4: number of interrupt sources; index 0 is the highest priority.
- FLUSH_CYCLES, 3: cycles flush is held to drain IF/ID/EX.
- INT_VEC, 32'h80000004: interrupt handler address.
- EXC_VEC, 32'h80000008: exception handler address.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- irq_src  in  NUM_SRC  level interrupt requests (bit0 timer, bit1 uart_send, others spare)
- exc_req  in  1  one-cycle exception pulse (PC overflow, undefined op, ALU overflow)
- exc_code  in  3  exception cause, valid with exc_req
- epc_in  in  32  PC+4 of oldest unsquashed instruction, sampled on take
- stall  in  1  pipeline cannot accept a vector this cycle (branch resolving in EX)
- eret  in  1  one-cycle handler-return pulse from ID
- cfg_we  in  1  register write strobe
- cfg_addr  in  2  register select
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  combinational read data
- flush  out  1  squash IF/ID/EX contents
- vector_valid  out  1  one-cycle pulse: PC loads vector_pc
- vector_pc  out  32  handler address
- kernel_mode  out  1  handler executing
- double_fault  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0, state IDLE, pending/mask/cause/epc 0, exc_pend 0, edge-detect history 0. Reset mid-operation aborts immediately to IDLE.
- Pending register:
  - pending[i] sets on a rising edge of irq_src[i], using a one-register edge detect.
  - It clears when the interrupt is taken, or when software writes 1 to that bit at addr 0.
  - A set event in the same cycle as a clear leaves the bit set.
- Exception latch:
  - exc_req outside KERNEL sets exc_pend and captures exc_code, so a pulse during stall is not lost.
  - exc_req in KERNEL leaves exc_pend unchanged and sets double_fault (cleared only by reset).
- Register map:
  - addr0 pending: read; writes are W1C.
  - addr1 mask: bit31 GIE, bits[NUM_SRC-1:0] per-source enable; read/write.
  - addr2 cause: bit31 1 = exception; bits[2:0] exc_code or source index; read-only.
  - addr3 epc: read-only.
  - Unused bits read 0.
- FSM states:
  - IDLE: when stall=0, take a pending event.
    - Exception (exc_pend=1) takes priority over interrupts: cause <= {1, exc_code}; exc_pend cleared.
    - Otherwise, if GIE=1 and (pending & mask) != 0, take the lowest enabled index: cause <= {0, idx}; pending[idx] cleared.
    - On either take: epc <= epc_in; go to FLUSH. With stall=1 the FSM stays in IDLE and pending state is held.
  - FLUSH: flush=1 for exactly FLUSH_CYCLES cycles (down-counter), then go to VECTOR.
  - VECTOR: vector_valid=1 for one cycle, vector_pc = cause[31] ? EXC_VEC : INT_VEC, kernel_mode goes to 1 the same cycle; next state KERNEL.
  - KERNEL: kernel_mode=1. eret moves the FSM to IDLE and kernel_mode goes to 0 the next cycle. Interrupt edges keep accumulating in pending.
- Latency:
  - An irq edge at cycle N yields pending at N+1, take at N+1 (IDLE, unstalled), flush N+2..N+1+FLUSH_CYCLES, and vector_valid at N+2+FLUSH_CYCLES.
  - An exc_req at cycle N is taken the same cycle (exc_pend visible combinationally), flush from N+1.
- vector_pc holds its value outside VECTOR. Only the vector_valid pulse acts on it.
- eret outside KERNEL is ignored.

Decomposition:
- Shared package irq_pkg:
  - FSM state enum (IDLE, FLUSH, VECTOR, KERNEL).
  - Register address constants.
  - Cause bit positions.
  - Default vector constants.
- One sub-module, prio_enc: a NUM_SRC-wide fixed-priority encoder producing a valid flag and an index.

Test Plan:
- mask=32'h80000001, timer edge at cycle 10 -> flush at cycles 12-14, vector_valid at 15 with vector_pc=32'h80000004, cause=0, pending bit0 cleared.
- exc_req with exc_code=3 and a uart edge in the same cycle, mask=32'h80000003 -> exception first: vector_pc=32'h80000008, cause=32'h80000003. After eret, uart taken with cause=1.
- stall held 5 cycles while exc_req pulses -> no flush during stall; flush starts the cycle after stall drops; epc equals epc_in sampled then.
- exc_req while in KERNEL -> double_fault=1 and stays 1 after eret; no second vector.
- GIE=0 with timer edge -> pending=1, no flush. Write 1 to addr0 -> pending=0. Write 0 to addr0 simultaneous with a new edge -> pending=1.
- reset asserted during FLUSH -> all outputs 0 in the same cycle; the FSM resumes in IDLE with pending=0.
